pwm_ramp: RTL

Duty-cycle ramp controller sitting directly upstream of the `pwm` generator. It accepts a target on-count and a period over a valid/ready handshake. It drives the `pwm` on-count and period inputs, walking the on-count one LSB at a time toward the target at a programmable step rate, so LED/motor loads fade instead of jumping. An optional breathe mode ramps continuously between 0 and the target.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_ramp_if.sv | 31 +++
 rtl/counter.sv | 13 +
 rtl/pwm_ramp.sv | 106 ++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and ramp state encoding for the pwm block family.
package pwm_pkg;
    localparam int PWM_BW_DEF = 3;
    localparam int DIV_BW_DEF = 8;
    typedef enum logic [1:0] {
        RAMP_IDLE = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;
endpackage

// File: rtl/pwm_ramp_if.sv
// pwm_ramp_if: load handshake and pwm drive bundle for pwm_ramp.
// breathe_i/stop_i exist only when PWM_RAMP_BREATHE_EN is defined.
interface pwm_ramp_if
    import pwm_pkg::*;
#(
    parameter int PWM_BW = PWM_BW_DEF,
    parameter int DIV_BW = DIV_BW_DEF
);
    logic              load_i;
    logic [PWM_BW-1:0] target_i;
    logic [PWM_BW-1:0] period_i;
    logic [DIV_BW-1:0] stepDiv_i;
    logic              ready_o;
    logic              busy_o;
    logic              done_o;
    logic [PWM_BW-1:0] onCnt_o;
    logic [PWM_BW-1:0] periodCnt_o;
`ifdef PWM_RAMP_BREATHE_EN
    logic              breathe_i;
    logic              stop_i;
    modport master (output load_i, target_i, period_i, stepDiv_i, breathe_i, stop_i,
                    input ready_o, busy_o, done_o, onCnt_o, periodCnt_o);
    modport slave  (input load_i, target_i, period_i, stepDiv_i, breathe_i, stop_i,
                    output ready_o, busy_o, done_o, onCnt_o, periodCnt_o);
`else
    modport master (output load_i, target_i, period_i, stepDiv_i,
                    input ready_o, busy_o, done_o, onCnt_o, periodCnt_o);
    modport slave  (input load_i, target_i, period_i, stepDiv_i,
                    output ready_o, busy_o, done_o, onCnt_o, periodCnt_o);
`endif
endinterface

// File: rtl/counter.sv
// counter: free-running up counter with synchronous active-low clear.
module counter #(
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          clr_ni,
    output logic [BW-1:0] cnt_o
);
    always_ff @(posedge clk_i or negedge nrst_i)
        if (!nrst_i) cnt_o <= '0;
        else         cnt_o <= clr_ni ? cnt_o + BW'(1) : '0;
endmodule

// File: rtl/pwm_ramp.sv
// pwm_ramp: walks the pwm on-count one LSB per prescaled step toward a loaded target.
// PWM_RAMP_BREATHE_EN adds continuous 0<->target breathing with a stop request.
module pwm_ramp
    import pwm_pkg::*;
#(
    parameter int PWM_BW = PWM_BW_DEF,
    parameter int DIV_BW = DIV_BW_DEF
) (
    input logic       clk_i,
    input logic       nrst_i,
    pwm_ramp_if.slave bus
);
    ramp_state_t       state, state_n;
    logic [PWM_BW-1:0] on_q, on_n, per_q, per_n, tgt_q, tgt_n, floor_v;
    logic [DIV_BW-1:0] div_q, div_n, pre;
    logic              done_q, done_n, accept, tc, step;
    logic              sess_q, brth_n;

    assign accept = bus.load_i && bus.ready_o;
    assign tc     = pre == div_q;
    assign step   = state != RAMP_IDLE && tc;

    counter #(.BW(DIV_BW)) u_pre (
        .clk_i (clk_i),
        .nrst_i(nrst_i),
        .clr_ni(!(accept || tc)),
        .cnt_o (pre)
    );

`ifdef PWM_RAMP_BREATHE_EN
    // sess_q marks a breathe session (down-ramps floor at 0); brth_q is the live flag stop clears
    logic brth_q, sess_n;
    always_ff @(posedge clk_i or negedge nrst_i)
        if (!nrst_i) begin
            brth_q <= 1'b0;
            sess_q <= 1'b0;
        end else begin
            brth_q <= brth_n;
            sess_q <= sess_n;
        end
`else
    assign sess_q = 1'b0;
    assign brth_n = 1'b0;
`endif

    assign floor_v = sess_q ? '0 : tgt_q;

    always_ff @(posedge clk_i or negedge nrst_i)
        if (!nrst_i) begin
            state  <= RAMP_IDLE;
            on_q   <= '0;
            per_q  <= '0;
            tgt_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            on_q   <= on_n;
            per_q  <= per_n;
            tgt_q  <= tgt_n;
            div_q  <= div_n;
            done_q <= done_n;
        end

    always_comb begin
        state_n = state;
        on_n    = on_q;
        per_n   = per_q;
        tgt_n   = tgt_q;
        div_n   = div_q;
        done_n  = 1'b0;
`ifdef PWM_RAMP_BREATHE_EN
        brth_n  = brth_q && !bus.stop_i;
        sess_n  = sess_q;
`endif
        if (accept) begin
            tgt_n   = bus.target_i > bus.period_i ? bus.period_i : bus.target_i;
            per_n   = bus.period_i;
            div_n   = bus.stepDiv_i;
            state_n = tgt_n > on_q ? RAMP_UP : tgt_n < on_q ? RAMP_DOWN : RAMP_IDLE;
            done_n  = tgt_n == on_q;
`ifdef PWM_RAMP_BREATHE_EN
            brth_n  = bus.breathe_i;
            sess_n  = bus.breathe_i;
`endif
        end else if (step && state == RAMP_UP) begin
            on_n = on_q + PWM_BW'(1);
            if (on_n == tgt_q) begin
                done_n  = 1'b1;
                state_n = sess_q ? RAMP_DOWN : RAMP_IDLE;
            end
        end else if (step && state == RAMP_DOWN) begin
            on_n = on_q - PWM_BW'(1);
            if (on_n == floor_v) begin
                done_n  = 1'b1;
                state_n = brth_n && tgt_q != '0 ? RAMP_UP : RAMP_IDLE;
            end
        end
    end

    assign bus.ready_o     = state == RAMP_IDLE;
    assign bus.busy_o      = state != RAMP_IDLE;
    assign bus.done_o      = done_q;
    assign bus.onCnt_o     = on_q;
    assign bus.periodCnt_o = per_q;
endmodule
